alu_issue_ctrl: RTL and testbench

//  Operand/issue stage directly upstream of the ALU. Accepts ALU commands over valid/ready, reads

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_issue_ctrl_if.sv | 49 ++++
 rtl/alu_regfile.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 111 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: op select values, flag bit positions, FSM states.
package alu_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_O = 1;
  localparam int F_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_rsvd(input logic [2:0] op);
    return op == OP_RSVD;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU operand/result and response signals of the ALU issue stage.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic             cmd_use_c;
  logic [AW-1:0]    cmd_rd;
  logic [AW-1:0]    cmd_ra;
  logic [AW-1:0]    cmd_rb;
  logic             cmd_imm_en;
  logic [WIDTH-1:0] cmd_imm;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_s;
  logic [WIDTH-1:0] alu_g;
  logic             alu_z;
  logic             alu_n;
  logic             alu_o;
  logic             alu_c;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_use_c, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_s,
    input  alu_g, alu_z, alu_n, alu_o, alu_c,
    output rsp_valid, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_use_c, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s,
    output alu_g, alu_z, alu_n, alu_o, alu_c,
    input  rsp_valid, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// Register file with two asynchronous read ports and one synchronous write port; R0 is hardwired 0.
module alu_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand/issue stage in front of the ALU: latches a command, presents registered operands,
// captures the ALU result and flags, writes back and returns a response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input logic              clk,
  input logic              rst,
  alu_issue_ctrl_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  state_t           state_q, state_d;
  logic             cmd_ready, rsp_valid, rf_we, accept;
  logic [WIDTH-1:0] rf_a, rf_b;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_result_q;
  logic [3:0]       alu_s_q, rsp_flags_q, flags_q, alu_flags;
  logic [AW-1:0]    rd_q;
  logic             rsp_err_q;

  alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (bus.alu_g),
    .raddr_a (bus.cmd_ra),
    .rdata_a (rf_a),
    .raddr_b (bus.cmd_rb),
    .rdata_b (rf_b)
  );

  assign accept = bus.cmd_valid && cmd_ready;

  always_comb begin
    alu_flags      = '0;
    alu_flags[F_Z] = bus.alu_z;
    alu_flags[F_N] = bus.alu_n;
    alu_flags[F_O] = bus.alu_o;
    alu_flags[F_C] = bus.alu_c;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_we     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = is_rsvd(bus.cmd_op[3:1]) ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        rf_we   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_s_q      <= '0;
      rd_q         <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Issue boundary: operands leave the register file and stay stable through EXEC.
      if (accept) begin
        if (is_rsvd(bus.cmd_op[3:1])) begin
          rsp_err_q <= 1'b1;
        end else begin
          alu_a_q <= rf_a;
          alu_b_q <= bus.cmd_imm_en ? bus.cmd_imm : rf_b;
          alu_s_q <= {bus.cmd_op[3:1], bus.cmd_use_c ? flags_q[F_C] : bus.cmd_op[0]};
          rd_q    <= bus.cmd_rd;
        end
      end
      // Capture boundary: ALU output is registered alongside the register-file writeback.
      if (state_q == ST_EXEC) begin
        rsp_result_q <= bus.alu_g;
        rsp_flags_q  <= alu_flags;
        flags_q      <= alu_flags;
        rsp_err_q    <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_s      = alu_s_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, directed scenarios, then random commands
// checked against an integer-arithmetic reference model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_issue_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_issue_ctrl #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural ALU, combinational from the registered operands.
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_bb, alu_res;
  always_comb begin
    alu_bb    = '0;
    alu_sum   = '0;
    alu_res   = '0;
    bus.alu_o = 1'b0;
    bus.alu_c = 1'b0;
    case (bus.alu_s[3:1])
      OP_PASS: alu_bb = '0;
      OP_ADD:  alu_bb = bus.alu_b;
      OP_SUB:  alu_bb = ~bus.alu_b;
      OP_DEC:  alu_bb = '1;
      default: alu_bb = '0;
    endcase
    case (bus.alu_s[3:1])
      OP_AND:  alu_res = bus.alu_a & bus.alu_b;
      OP_OR:   alu_res = bus.alu_a | bus.alu_b;
      OP_XOR:  alu_res = bus.alu_a ^ bus.alu_b;
      OP_RSVD: alu_res = '0;
      default: begin
        alu_sum   = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {{WIDTH{1'b0}}, bus.alu_s[0]};
        alu_res   = alu_sum[WIDTH-1:0];
        bus.alu_c = alu_sum[WIDTH];
        bus.alu_o = (bus.alu_a[WIDTH-1] == alu_bb[WIDTH-1]) &&
                    (alu_res[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
    endcase
  end
  assign bus.alu_g = alu_res;
  assign bus.alu_z = (alu_res == '0);
  assign bus.alu_n = alu_res[WIDTH-1];

  // Reference state
  logic [7:0] rf_m [NREGS];
  logic       c_m;
  logic [7:0] last_res;
  logic [3:0] last_f;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) rf_m[i] = 8'h00;
    c_m = 1'b0;
    last_res = 8'h00;
    last_f = 4'h0;
  endtask

  function automatic void alu_model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] g, output logic [3:0] f);
    int ua, ub, sa, sb, ci, u, sr;
    bit arith;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(s[0]);
    sr = 0;
    arith = 1'b1;
    case (s[3:1])
      3'd0: begin u = ua + ci;             sr = sa + ci;          end
      3'd1: begin u = ua + ub + ci;        sr = sa + sb + ci;     end
      3'd2: begin u = ua + (255 - ub) + ci; sr = sa - sb - 1 + ci; end
      3'd3: begin u = ua + 255 + ci;       sr = sa - 1 + ci;      end
      3'd4: begin u = ua & ub; arith = 1'b0; end
      3'd5: begin u = ua | ub; arith = 1'b0; end
      3'd6: begin u = ua ^ ub; arith = 1'b0; end
      default: begin u = 0; arith = 1'b0; end
    endcase
    g = u[7:0];
    f = {g == 8'h00, g[7], arith && (sr > 127 || sr < -128), arith && (u > 255)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input bit use_c, input int rd, input int ra,
                         input int rb, input bit imm_en, input logic [7:0] imm,
                         input int hold, input bit rst_exec);
    logic [7:0] a, b, g;
    logic [3:0] s, f;
    bit ill;
    int n;
    a = rf_m[ra];
    b = imm_en ? imm : rf_m[rb];
    s = {op[3:1], use_c ? c_m : op[0]};
    ill = (op[3:1] == 3'b111);
    g = last_res;
    f = last_f;
    if (!ill) alu_model(s, a, b, g, f);

    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_use_c  = use_c;
    bus.cmd_rd     = AW'(rd);
    bus.cmd_ra     = AW'(ra);
    bus.cmd_rb     = AW'(rb);
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      return;
    end

    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 4'($urandom);
    bus.cmd_ra     = AW'($urandom);
    bus.cmd_rb     = AW'($urandom);
    bus.cmd_rd     = AW'($urandom);
    bus.cmd_imm    = 8'($urandom);
    check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    if (!ill) begin
      check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("exec_alu_a", 32'(bus.alu_a), 32'(a));
      check("exec_alu_b", 32'(bus.alu_b), 32'(b));
      check("exec_alu_s", 32'(bus.alu_s), 32'(s));
      if (rst_exec) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_exec_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_exec_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_exec_result", 32'(bus.rsp_result), 32'd0);
        model_reset();
        return;
      end
      @(negedge clk);
    end

    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_result", 32'(bus.rsp_result), 32'(g));
    check("rsp_flags", 32'(bus.rsp_flags), 32'(f));
    check("rsp_err", 32'(bus.rsp_err), 32'(ill));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_result", 32'(bus.rsp_result), 32'(g));
      check("hold_flags", 32'(bus.rsp_flags), 32'(f));
      check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    if (!ill) begin
      if (rd != 0) rf_m[rd] = g;
      c_m = f[0];
      last_res = g;
      last_f = f;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 4'h0;
    bus.cmd_use_c  = 1'b0;
    bus.cmd_rd     = '0;
    bus.cmd_ra     = '0;
    bus.cmd_rb     = '0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = 8'h00;
    bus.rsp_ready  = 1'b0;
    model_reset();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_alu_a", 32'(bus.alu_a), 32'd0);
    check("reset_alu_b", 32'(bus.alu_b), 32'd0);
    check("reset_alu_s", 32'(bus.alu_s), 32'd0);
    check("reset_result", 32'(bus.rsp_result), 32'd0);
    check("reset_flags", 32'(bus.rsp_flags), 32'd0);
    check("reset_err", 32'(bus.rsp_err), 32'd0);

    // Overflow into sign bit, then subtract-with-carry to zero
    run_cmd(4'b0010, 0, 1, 0, 0, 1, 8'h7F, 0, 0);
    run_cmd(4'b0010, 0, 2, 1, 0, 1, 8'h01, 0, 0);
    check("dir_r2_result", 32'(last_res), 32'h80);
    check("dir_r2_flags", 32'(last_f), 32'b0110);
    run_cmd(4'b0101, 0, 3, 1, 1, 0, 8'h00, 0, 0);
    check("dir_r3_flags", 32'(last_f), 32'b1001);

    // Carry chain through stored C
    run_cmd(4'b0010, 0, 4, 0, 0, 1, 8'hFF, 0, 0);
    run_cmd(4'b0010, 0, 5, 4, 0, 1, 8'h01, 0, 0);
    run_cmd(4'b0010, 1, 6, 0, 0, 1, 8'h00, 0, 0);
    check("dir_chain_result", 32'(last_res), 32'h01);

    // Writes to R0 are dropped
    run_cmd(4'b0010, 0, 0, 0, 0, 1, 8'h55, 0, 0);
    run_cmd(4'b1000, 0, 7, 0, 0, 1, 8'hFF, 0, 0);
    run_cmd(4'b0010, 0, 7, 0, 0, 0, 8'h00, 0, 0);

    // Backpressure, then illegal op leaves state untouched
    run_cmd(4'b1100, 0, 5, 1, 2, 0, 8'h00, 5, 0);
    run_cmd(4'b1110, 0, 1, 2, 3, 0, 8'h00, 2, 0);
    run_cmd(4'b0010, 1, 7, 1, 0, 1, 8'h00, 0, 0);

    // Reset landing on EXEC
    run_cmd(4'b0010, 0, 3, 0, 0, 1, 8'hAA, 0, 1);
    run_cmd(4'b0010, 0, 4, 3, 0, 1, 8'h00, 0, 0);

    for (int k = 0; k < 60; k++) begin
      run_cmd(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, NREGS - 1),
              $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
              1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
